// File: rtl/r_fifo_pkg.sv
// Shared defaults and packet-tracking state type for the packet FIFO.
package r_fifo_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int LEN_LSB_DEF    = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_t;
endpackage

// File: rtl/r_fifo_mem.sv
// 1-write/1-read register array with asynchronous read; contents are never reset.
module r_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/r_pkt_fifo.sv
// Packet FIFO: each entry carries a header marker; reads are tracked against the
// header length field to flag packet completion and framing errors.
module r_pkt_fifo
    import r_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 16,
    parameter int LEN_LSB    = LEN_LSB_DEF,
    parameter int AFULL_LVL  = DEPTH - 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    soft_reset,
    input  logic                    write_enb,
    input  logic                    read_enb,
    input  logic                    lfd_state,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    pkt_done,
    output logic                    ovf_err,
    output logic                    udf_err,
    output logic                    frm_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = DATA_WIDTH - LEN_LSB;
    localparam int RW = LW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [RW-1:0]         rem_q, rem_d;
    pkt_state_t            state_q, state_d;
    logic                  pkt_done_q, pkt_done_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d, frm_q, frm_d;
    logic                  wr_acc, rd_acc, rd_hdr;
    logic [DATA_WIDTH:0]   rd_word;
    logic [LW-1:0]         rd_len;

    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= AFULL_C);
    assign wr_acc      = write_enb && !full;
    assign rd_acc      = read_enb && !empty;
    assign rd_hdr      = rd_word[DATA_WIDTH];
    assign rd_len      = rd_word[DATA_WIDTH-1:LEN_LSB];

    r_fifo_mem #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc && !soft_reset),
        .wr_addr (wr_ptr_q),
        .wr_data ({lfd_state, data_in}),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_word)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        rem_d      = rem_q;
        state_d    = state_q;
        pkt_done_d = 1'b0;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        frm_d      = frm_q;
        if (soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            data_out_d = '0;
            rem_d      = '0;
            state_d    = IDLE;
        end else begin
            ovf_d   = ovf_q || (write_enb && full);
            udf_d   = udf_q || (read_enb && empty);
            count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                data_out_d = rd_word[DATA_WIDTH-1:0];
                // rem counts payload plus the trailing parity byte
                if (rd_hdr) begin
                    if (state_q == IN_PKT) frm_d = 1'b1;
                    rem_d   = RW'(rd_len) + RW'(1);
                    state_d = IN_PKT;
                end else if (state_q == IDLE) begin
                    frm_d = 1'b1;
                end else if (rem_q == RW'(1)) begin
                    pkt_done_d = 1'b1;
                    rem_d      = '0;
                    state_d    = IDLE;
                end else begin
                    rem_d = rem_q - RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            rem_q      <= '0;
            state_q    <= IDLE;
            pkt_done_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            frm_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            rem_q      <= rem_d;
            state_q    <= state_d;
            pkt_done_q <= pkt_done_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            frm_q      <= frm_d;
        end
    end

    assign data_out = data_out_q;
    assign count    = count_q;
    assign pkt_done = pkt_done_q;
    assign ovf_err  = ovf_q;
    assign udf_err  = udf_q;
    assign frm_err  = frm_q;
endmodule
